// File: rtl/mem_port_scheduler.sv
// Shares one multicycle memory port between I/D block fills and a posted write buffer; D wins over I.
// Fill reads start the cycle after a miss is seen, delayed by drained writes; stores are refused when full or draining.
module mem_port_scheduler #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WB_DEPTH    = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_done,
  output logic                           d_done,
  input  logic                           wr_req,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           wr_ack,
  output logic                           wb_full,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_rvalid,
  output logic                           busy
);

  localparam int WI_W  = $clog2(BLOCK_WORDS);
  localparam int TAG_W = ADDR_W - WI_W - 1;
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(BLOCK_WORDS - 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("MEM_LAT must be at least 1");
  end
  if ((1 << PTR_W) != WB_DEPTH) begin : g_bad_depth
    $error("WB_DEPTH must be a power of two");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_FILL_I,
    S_FILL_D,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [TAG_W-1:0]  blk_q, blk_d;
  logic [WI_W-1:0]   iss_q, iss_d;
  logic [WI_W-1:0]   ret_q, ret_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
  logic [ADDR_W-1:0] wb_addr_d [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_d [WB_DEPTH];

  logic              push;
  logic              pop;
  logic              wb_hit;
  logic [TAG_W-1:0]  sel_tag;
  logic [PTR_W-1:0]  wb_off [WB_DEPTH];
  logic [WB_DEPTH-1:0] wb_vld;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{i_miss_addr[WI_W:0], d_miss_addr[WI_W:0]};

  assign busy    = (state_q != S_IDLE);
  assign wb_full = (cnt_q == CNT_W'(WB_DEPTH));
  assign wr_ack  = wr_req & ~wb_full & (state_q != S_DRAIN);
  assign push    = wr_ack;
  assign sel_tag = d_miss ? d_miss_addr[ADDR_W-1:WI_W+1] : i_miss_addr[ADDR_W-1:WI_W+1];

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    wb_hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      wb_off[i] = PTR_W'(i) - head_q;
      wb_vld[i] = ({1'b0, wb_off[i]} < cnt_q);
      if (wb_vld[i] && (wb_addr_q[i][ADDR_W-1:WI_W+1] == sel_tag)) begin
        wb_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    blk_d        = blk_q;
    iss_d        = iss_q;
    ret_d        = ret_q;
    pop          = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_data    = '0;
    fill_word    = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_miss || i_miss) begin
          owner_d = d_miss;
          blk_d   = sel_tag;
          iss_d   = '0;
          ret_d   = '0;
          if (wb_hit) begin
            state_d = S_DRAIN;
          end else begin
            state_d = d_miss ? S_FILL_D : S_FILL_I;
          end
        end else if (cnt_q != '0) begin
          pop = 1'b1;
        end
      end
      S_DRAIN: begin
        pop = (cnt_q != '0);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = owner_q ? S_FILL_D : S_FILL_I;
        end
      end
      S_FILL_I, S_FILL_D: begin
        mem_en   = 1'b1;
        mem_addr = {blk_q, iss_q, 1'b0};
        iss_d    = iss_q + 1'b1;
        if (iss_q == LAST_WORD) begin
          state_d = S_WAIT;
        end
      end
      default: ;
    endcase

    // Returns are only meaningful while a fill is outstanding; anything else is stale.
    if ((state_q == S_FILL_I || state_q == S_FILL_D || state_q == S_WAIT) && mem_rvalid) begin
      i_fill_valid = ~owner_q;
      d_fill_valid = owner_q;
      fill_data    = mem_rdata;
      fill_word    = ret_q;
      ret_d        = ret_q + 1'b1;
      if (ret_q == LAST_WORD) begin
        i_done  = ~owner_q;
        d_done  = owner_q;
        state_d = S_IDLE;
      end
    end

    if (pop) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = wb_addr_q[head_q];
      mem_wdata = wb_data_q[head_q];
    end
  end

  always_comb begin
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (push) begin
      wb_addr_d[tail_q] = wr_addr;
      wb_data_d[tail_q] = wr_data;
    end
    head_d = head_q + PTR_W'(pop);
    tail_d = tail_q + PTR_W'(push);
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      blk_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      blk_q     <= blk_d;
      iss_q     <= iss_d;
      ret_q     <= ret_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

endmodule
